iir_lpf_cascade: RTL and testbench

Parametrised cascade of first-order leaky-integrator IIR low-pass stages. It is the successor to the single-stage filter, adding a configurable stage count, a runtime-selectable cutoff shift, valid strobes in both directions and a synchronous clear. It sits between the ADC sample path and downstream demodulation/decimation logic, accepting one signed sample per strobe at up to one sample per clock.

---
 rtl/iir_lpf_cascade_if.sv | 23 ++
 rtl/iir_lpf_cascade.sv | 113 +++++++++++
 tb/tb_iir_lpf_cascade.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/iir_lpf_cascade_if.sv
// Sample-stream bundle for the IIR low-pass cascade: input strobe, cutoff,
// synchronous clear, and the registered filtered output.
interface iir_lpf_cascade_if #(
    parameter int WIDTH = 14,
    parameter int KW    = 5
);
    logic                    clear;
    logic signed [WIDTH-1:0] din;
    logic                    din_valid;
    logic        [KW-1:0]    k_shift;
    logic signed [WIDTH-1:0] dout;
    logic                    dout_valid;

    modport master (
        output clear, din, din_valid, k_shift,
        input  dout, dout_valid
    );

    modport slave (
        input  clear, din, din_valid, k_shift,
        output dout, dout_valid
    );
endinterface

// File: rtl/iir_lpf_cascade.sv
// Cascade of first-order leaky-integrator low-pass stages. Each sample carries
// its own clamped shift down the pipeline alongside its valid bit.
module iir_lpf_stage #(
    parameter int SW = 30,
    parameter int KW = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic signed [SW-1:0] i_x,
    input  logic        [KW-1:0] i_k,
    output logic signed [SW-1:0] o_s
);
    logic signed [SW-1:0] r_s;
    logic signed [SW:0]   w_diff;
    logic signed [SW:0]   w_step;

    // One extra bit keeps x - s exact before the floor shift.
    assign w_diff = {i_x[SW-1], i_x} - {r_s[SW-1], r_s};
    assign w_step = w_diff >>> i_k;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_s <= '0;
        else if (i_clear)
            r_s <= '0;
        else if (i_en)
            r_s <= r_s + w_step[SW-1:0];
    end

    assign o_s = r_s;
endmodule

module iir_lpf_cascade #(
    parameter int WIDTH     = 14,
    parameter int FRAC      = 16,
    parameter int STAGES    = 2,
    parameter int KW        = 5,
    parameter int MAX_SHIFT = 20
) (
    input  logic                i_clk,
    input  logic                i_rst,
    iir_lpf_cascade_if.slave    bus
);
    localparam int SW = WIDTH + FRAC;
    localparam logic [KW-1:0] MAXK = KW'(MAX_SHIFT);

    logic [STAGES-1:0]             r_vld_pipe;
    logic [STAGES:0]               w_en;
    logic [STAGES-1:0][KW-1:0]     w_k;
    logic [STAGES:0][SW-1:0]       w_x;
    logic signed [WIDTH-1:0]       r_dout;
    logic                          r_dout_valid;

    assign w_en   = {r_vld_pipe, bus.din_valid};
    assign w_k[0] = (bus.k_shift > MAXK) ? MAXK : bus.k_shift;
    assign w_x[0] = {bus.din, {FRAC{1'b0}}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_vld_pipe <= '0;
        else if (bus.clear)
            r_vld_pipe <= '0;
        else
            r_vld_pipe <= w_en[STAGES-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            iir_lpf_stage #(.SW(SW), .KW(KW)) u_stage (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_clear (bus.clear),
                .i_en    (w_en[gi]),
                .i_x     (w_x[gi]),
                .i_k     (w_k[gi]),
                .o_s     (w_x[gi+1])
            );
        end
        // Stage i>0 uses the shift its sample was accepted with.
        for (gi = 1; gi < STAGES; gi++) begin : g_kpipe
            logic [KW-1:0] r_k;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst)
                    r_k <= '0;
                else if (bus.clear)
                    r_k <= '0;
                else
                    r_k <= w_k[gi-1];
            end
            assign w_k[gi] = r_k;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (bus.clear) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_en[STAGES];
            if (w_en[STAGES])
                r_dout <= w_x[STAGES][SW-1:FRAC];
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
endmodule

// File: tb/tb_iir_lpf_cascade.sv
// Scoreboard bench: one-stage and two-stage cascades driven in parallel,
// expected samples come from a floor-arithmetic model updated per strobe.
module tb_iir_lpf_cascade;
    typedef struct {
        longint val;
        int     edge_n;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic               din_valid;
    logic signed [13:0] din;
    logic        [4:0]  k_shift;

    int     n_cmp = 0;
    int     n_err = 0;
    int     edge_cnt = 0;
    exp_t   q1[$];
    exp_t   q2[$];
    longint m1, m2a, m2b;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    iir_lpf_cascade_if #(.WIDTH(14), .KW(5)) u_if1 ();
    iir_lpf_cascade_if #(.WIDTH(14), .KW(5)) u_if2 ();

    assign u_if1.clear = clear;  assign u_if2.clear = clear;
    assign u_if1.din = din;      assign u_if2.din = din;
    assign u_if1.din_valid = din_valid;  assign u_if2.din_valid = din_valid;
    assign u_if1.k_shift = k_shift;      assign u_if2.k_shift = k_shift;

    iir_lpf_cascade #(.STAGES(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(u_if1.slave));
    iir_lpf_cascade #(.STAGES(2)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(u_if2.slave));

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lpf(input longint s, input longint x, input int k);
        return s + ((x - s) >>> k);
    endfunction

    task automatic model_reset();
        m1 = 0; m2a = 0; m2b = 0;
        q1.delete(); q2.delete();
    endtask

    task automatic send(input int v, input int k);
        int   kk;
        exp_t e;
        kk = (k > 20) ? 20 : k;
        din = 14'(v); k_shift = 5'(k); din_valid = 1'b1; clear = 1'b0;
        m1  = lpf(m1, longint'(v) * 65536, kk);
        m2a = lpf(m2a, longint'(v) * 65536, kk);
        m2b = lpf(m2b, m2a, kk);
        e.edge_n = edge_cnt + 1;
        e.val = m1 >>> 16;  q1.push_back(e);
        e.val = m2b >>> 16; q2.push_back(e);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear(input bit with_valid);
        clear = 1'b1; din_valid = with_valid; din = 14'sd8000; k_shift = 5'd3;
        @(posedge clk); #1;
        clear = 1'b0; din_valid = 1'b0;
        model_reset();
        chk("clr_dout1", u_if1.dout, 0);       chk("clr_dout2", u_if2.dout, 0);
        chk("clr_vld1", u_if1.dout_valid, 0);  chk("clr_vld2", u_if2.dout_valid, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (u_if1.dout_valid) begin
                if (q1.size() == 0) chk("spurious1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("dout1", u_if1.dout, e.val);
                    chk("lat1", edge_cnt - e.edge_n, 1);
                end
            end
            if (u_if2.dout_valid) begin
                if (q2.size() == 0) chk("spurious2", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("dout2", u_if2.dout, e.val);
                    chk("lat2", edge_cnt - e.edge_n, 2);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; din_valid = 1'b1; din = 14'sd5000; k_shift = 5'd1;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            chk("rst_dout1", u_if1.dout, 0);       chk("rst_dout2", u_if2.dout, 0);
            chk("rst_vld1", u_if1.dout_valid, 0);  chk("rst_vld2", u_if2.dout_valid, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; din_valid = 1'b0;

        // step response
        repeat (12) send(1000, 1);
        idle(3);
        chk("step_pos_hold", u_if1.dout, 999);
        do_clear(1'b0);
        repeat (5) send(-1000, 1);
        idle(3);
        chk("step_neg_hold", u_if1.dout, -969);

        // pass-through ramp
        do_clear(1'b0);
        for (int i = 0; i < 40; i++) send(i, 0);
        idle(3);
        chk("ramp_last2", u_if2.dout, 39);

        // strobe gaps
        do_clear(1'b0);
        for (int i = 0; i < 10; i++) begin send(4000, 2); idle(2); end
        chk("gap_hold2", u_if2.dout, m2b >>> 16);

        // clear with coincident strobe, then fresh sample
        do_clear(1'b0);
        repeat (10) send(8000, 3);
        do_clear(1'b1);
        send(8000, 3);
        idle(3);
        chk("clr_first1", u_if1.dout, 1000);
        chk("clr_first2", u_if2.dout, 125);

        // oversize shift clamps to MAX_SHIFT
        do_clear(1'b0);
        for (int i = 0; i < 30; i++) send((i % 2) ? 8191 : -8192 + i * 100, 31);
        for (int i = 0; i < 10; i++) send(8191, 25);
        idle(3);

        // extremes
        do_clear(1'b0);
        for (int i = 0; i < 1000; i++) send((i % 2) ? -8192 : 8191, 0);
        idle(3);
        chk("ext_k0_last2", u_if2.dout, -8192);
        do_clear(1'b0);
        for (int i = 0; i < 1000; i++) send((i % 2) ? -8192 : 8191, 20);
        idle(3);

        // async reset mid-stream
        do_clear(1'b0);
        repeat (6) send(3000, 1);
        send(3000, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout1", u_if1.dout, 0);       chk("arst_dout2", u_if2.dout, 0);
        chk("arst_vld1", u_if1.dout_valid, 0);  chk("arst_vld2", u_if2.dout_valid, 0);
        model_reset();
        din = 14'sd5000; din_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("arst_hold1", u_if1.dout, 0);  chk("arst_hold2", u_if2.dout, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; din_valid = 1'b0;
        send(2000, 0);
        idle(4);
        chk("post_rst1", u_if1.dout, 2000);

        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
